// File: rtl/stopwatch_mux_param_if.sv
// Board-side bundle: button levels in, anode/segment drive and zero flag out.
// Combinational wiring only; no latency, no backpressure.
interface stopwatch_mux_param_if #(
  parameter int DIGITS = 4
);
  logic              go;
  logic              clr;
  logic              up;
  logic              down;
  logic [DIGITS-1:0] an;
  logic [7:0]        sseg;
  logic              at_zero;

  modport master (output go, clr, up, down, input an, sseg, at_zero);
  modport slave  (input go, clr, up, down, output an, sseg, at_zero);
endinterface

// File: rtl/stopwatch_mux_param.sv
// Up/down BCD stopwatch with muxed 7-seg driver; LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: count updates on the tick edge, an/sseg registered one cycle after digit select.
// Backpressure: none; button levels are sampled every cycle.
module stopwatch_mux_param #(
  parameter int DIGITS       = 4,
  parameter int TICK_DIV     = 5000000,
  parameter int REFRESH_BITS = 18,
  parameter int WRAP         = 1,
  parameter int DP_POS       = 1
) (
  input logic                  clk,
  input logic                  reset,
  stopwatch_mux_param_if.slave sw
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    SSEG_RST   = (DP_POS == 0) ? 8'h40 : 8'hC0;

  typedef logic [DIGITS-1:0][3:0] bcd_t;

  bcd_t                    count_q, count_d, cnt_inc, cnt_dec;
  logic [PW-1:0]           presc_q, presc_d;
  logic                    dir_q, dir_d;  // 1 = counting up
  logic                    at_zero_q, at_zero_d;
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [7:0]              sseg_q, sseg_d;
  logic                    tick, carry, borrow, is_zero;
  logic [SW-1:0]           sel;
  logic [3:0]              digit;
  logic [DIGITS-1:0]       lead_zero;
  logic                    hz;
  int                      cur;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h40;
    endcase
  endfunction

  always_comb begin
    cnt_inc = count_q;
    cnt_dec = count_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[i] >= 4'd9) begin
          cnt_inc[i] = 4'd0;
        end else begin
          cnt_inc[i] = count_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[i] == 4'd0) begin
          cnt_dec[i] = 4'd9;
        end else begin
          cnt_dec[i] = count_q[i] - 4'd1;
          borrow     = 1'b0;
        end
      end
    end
    is_zero = (count_q == '0);
  end

  always_comb begin
    tick    = sw.go && (presc_q == PRESC_LAST);
    presc_d = presc_q;
    count_d = count_q;
    if (sw.go) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    // carry out of the top digit means the count was all 9s
    if (tick) begin
      if (dir_q) begin
        if (!(carry && (WRAP == 0))) count_d = cnt_inc;
      end else if (!is_zero) begin
        count_d = cnt_dec;
      end
    end
    if (sw.clr) begin
      count_d = '0;
      presc_d = '0;
    end
    dir_d = dir_q;
    if (sw.up && !sw.down)      dir_d = 1'b1;
    else if (sw.down && !sw.up) dir_d = 1'b0;
    at_zero_d = (count_d == '0);
  end

  always_comb begin
    hz = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hz           = hz && (count_q[i] == 4'd0);
      lead_zero[i] = hz;
    end
    sel   = refresh_q[REFRESH_BITS-1 -: SW];
    cur   = 0;
    digit = count_q[0];
    an_d  = ~DIGITS'(1);
    // select codes past the last digit fall back to digit 0
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == SW'(i)) begin
        cur   = i;
        digit = count_q[i];
        an_d  = ~(DIGITS'(1) << i);
      end
    end
    sseg_d[6:0] = seg7(digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (cur != 0 && lead_zero[cur]) sseg_d[6:0] = 7'h7F;
`endif
    sseg_d[7] = (cur == DP_POS) ? 1'b0 : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      presc_q   <= '0;
      dir_q     <= 1'b1;
      at_zero_q <= 1'b1;
      refresh_q <= '0;
      an_q      <= ~DIGITS'(1);
      sseg_q    <= SSEG_RST;
    end else begin
      count_q   <= count_d;
      presc_q   <= presc_d;
      dir_q     <= dir_d;
      at_zero_q <= at_zero_d;
      refresh_q <= refresh_q + REFRESH_BITS'(1);
      an_q      <= an_d;
      sseg_q    <= sseg_d;
    end
  end

  assign sw.an      = an_q;
  assign sw.sseg    = sseg_q;
  assign sw.at_zero = at_zero_q;
endmodule

// File: tb/tb_stopwatch_mux_param.sv
// Directed bench for stopwatch_mux_param: 4-digit wrap, 2-digit wrap and 2-digit saturate builds.
module tb_stopwatch_mux_param;
  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cnt;

  logic [7:0] q4[$];
  logic [7:0] q2w[$];
  logic [7:0] q2s[$];

  always #5 clk = ~clk;

  stopwatch_mux_param_if #(.DIGITS(4)) if4 ();
  stopwatch_mux_param_if #(.DIGITS(2)) if2w ();
  stopwatch_mux_param_if #(.DIGITS(2)) if2s ();

  stopwatch_mux_param #(.DIGITS(4), .TICK_DIV(4), .REFRESH_BITS(4), .WRAP(1), .DP_POS(1))
    dut4 (.clk(clk), .reset(reset), .sw(if4));
  stopwatch_mux_param #(.DIGITS(2), .TICK_DIV(2), .REFRESH_BITS(3), .WRAP(1), .DP_POS(1))
    dut2w (.clk(clk), .reset(reset), .sw(if2w));
  stopwatch_mux_param #(.DIGITS(2), .TICK_DIV(2), .REFRESH_BITS(3), .WRAP(0), .DP_POS(1))
    dut2s (.clk(clk), .reset(reset), .sw(if2s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] seg_code(input int d);
    case (d)
      0: seg_code = 8'hC0;  1: seg_code = 8'hF9;  2: seg_code = 8'hA4;
      3: seg_code = 8'hB0;  4: seg_code = 8'h99;  5: seg_code = 8'h92;
      6: seg_code = 8'h82;  7: seg_code = 8'hF8;  8: seg_code = 8'h80;
      default: seg_code = 8'h90;
    endcase
  endfunction

  // Expected pattern for digit i of decimal value v, decimal point on digit 1.
  function automatic logic [7:0] exp_seg(input int v, input int i);
    int p = 1;
    logic [7:0] s;
    for (int k = 0; k < i; k++) p = p * 10;
    s = seg_code((v / p) % 10);
    if (i == 1) s[7] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (i != 0 && v < p) s[6:0] = 7'h7F;
`endif
    return s;
  endfunction

  task automatic push4(input int v);
    for (int i = 0; i < 4; i++) q4.push_back(exp_seg(v, i));
  endtask

  task automatic push2(input int vw, input int vs);
    for (int i = 0; i < 2; i++) begin
      q2w.push_back(exp_seg(vw, i));
      q2s.push_back(exp_seg(vs, i));
    end
  endtask

  // Watch a full refresh period of every DUT, then compare against queued expectations.
  task automatic scan();
    logic [7:0] s4[4];
    logic [7:0] s2w[2];
    logic [7:0] s2s[2];
    logic oh4 = 1'b1, oh2w = 1'b1, oh2s = 1'b1;
    for (int i = 0; i < 4; i++) s4[i] = 8'hxx;
    for (int i = 0; i < 2; i++) begin s2w[i] = 8'hxx; s2s[i] = 8'hxx; end
    repeat (16) begin
      @(negedge clk);
      case (if4.an)
        4'b1110: s4[0] = if4.sseg;
        4'b1101: s4[1] = if4.sseg;
        4'b1011: s4[2] = if4.sseg;
        4'b0111: s4[3] = if4.sseg;
        default: oh4 = 1'b0;
      endcase
      case (if2w.an)
        2'b10:   s2w[0] = if2w.sseg;
        2'b01:   s2w[1] = if2w.sseg;
        default: oh2w = 1'b0;
      endcase
      case (if2s.an)
        2'b10:   s2s[0] = if2s.sseg;
        2'b01:   s2s[1] = if2s.sseg;
        default: oh2s = 1'b0;
      endcase
    end
    if (q4.size() != 0) begin
      check("an4_onehot", {31'd0, oh4}, 32'd1);
      for (int i = 0; i < 4; i++) check($sformatf("d4_dig%0d", i), {24'd0, s4[i]}, {24'd0, q4.pop_front()});
    end
    if (q2w.size() != 0) begin
      check("an2w_onehot", {31'd0, oh2w}, 32'd1);
      for (int i = 0; i < 2; i++) check($sformatf("d2w_dig%0d", i), {24'd0, s2w[i]}, {24'd0, q2w.pop_front()});
    end
    if (q2s.size() != 0) begin
      check("an2s_onehot", {31'd0, oh2s}, 32'd1);
      for (int i = 0; i < 2; i++) check($sformatf("d2s_dig%0d", i), {24'd0, s2s[i]}, {24'd0, q2s.pop_front()});
    end
  endtask

  initial begin
    reset = 1'b1;
    {if4.go, if4.clr, if4.up, if4.down}     = 4'b0;
    {if2w.go, if2w.clr, if2w.up, if2w.down} = 4'b0;
    {if2s.go, if2s.clr, if2s.up, if2s.down} = 4'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_an", {28'd0, if4.an}, 32'h0000000E);
    check("rst_sseg", {24'd0, if4.sseg}, 32'h000000C0);
    check("rst_at_zero", {31'd0, if4.at_zero}, 32'd1);
    check("rst_at_zero_2w", {31'd0, if2w.at_zero}, 32'd1);

    // Count up 10 ticks; first tick lands on the 4th enabled cycle.
    if4.go = 1'b1;
    cyc(3);
    check("pre_first_tick", {31'd0, if4.at_zero}, 32'd1);
    cyc(1);
    check("post_first_tick", {31'd0, if4.at_zero}, 32'd0);
    cyc(36);
    if4.go = 1'b0;
    push4(10);
    scan();

    // Clear, climb to 3, then count down through zero.
    if4.clr = 1'b1; cyc(1); if4.clr = 1'b0;
    check("clr_at_zero", {31'd0, if4.at_zero}, 32'd1);
    if4.go = 1'b1; cyc(12); if4.go = 1'b0;
    push4(3);
    scan();
    if4.down = 1'b1; cyc(1); if4.down = 1'b0;
    cnt = 3;
    for (int k = 0; k < 5; k++) begin
      if4.go = 1'b1; cyc(4); if4.go = 1'b0;
      cnt = (cnt > 0) ? cnt - 1 : 0;
      check($sformatf("down_at_zero_%0d", k), {31'd0, if4.at_zero}, {31'd0, cnt == 0});
      push4(cnt);
      scan();
    end

    // Conflicting up/down mid-count must leave the direction alone.
    if4.up = 1'b1; cyc(1); if4.up = 1'b0;
    if4.go = 1'b1;
    cyc(10);
    if4.up = 1'b1; if4.down = 1'b1;
    cyc(3);
    if4.up = 1'b0; if4.down = 1'b0;
    cyc(5);
    if4.go = 1'b0;
    cyc(20);
    push4(4);
    scan();
    // Prescaler was frozen at 2, so two more enabled cycles complete a tick.
    if4.go = 1'b1; cyc(2); if4.go = 1'b0;
    push4(5);
    scan();
    if4.clr = 1'b1; cyc(1); if4.clr = 1'b0;
    check("clr2_at_zero", {31'd0, if4.at_zero}, 32'd1);
    push4(0);
    scan();

    // Clear coinciding with a due tick discards that tick and restarts the prescaler.
    if4.go = 1'b1;
    cyc(3);
    if4.clr = 1'b1; cyc(1); if4.clr = 1'b0;
    check("clr_tick_discard", {31'd0, if4.at_zero}, 32'd1);
    cyc(3);
    check("presc_restarted", {31'd0, if4.at_zero}, 32'd1);
    cyc(1);
    if4.go = 1'b0;
    check("tick_after_clr", {31'd0, if4.at_zero}, 32'd0);
    push4(1);
    scan();

    // Two-digit builds: 99 ticks, then one more to hit the end-of-range policy.
    if2w.go = 1'b1; if2s.go = 1'b1;
    cyc(198);
    if2w.go = 1'b0; if2s.go = 1'b0;
    check("w99_at_zero", {31'd0, if2w.at_zero}, 32'd0);
    check("s99_at_zero", {31'd0, if2s.at_zero}, 32'd0);
    push2(99, 99);
    scan();
    if2w.go = 1'b1; if2s.go = 1'b1;
    cyc(2);
    if2w.go = 1'b0; if2s.go = 1'b0;
    check("wrap_at_zero", {31'd0, if2w.at_zero}, 32'd1);
    check("sat_at_zero", {31'd0, if2s.at_zero}, 32'd0);
    push2(0, 99);
    scan();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
